rx_frame_sender: RTL and testbench

Reads completed RX sample pages out of the receiver's double-buffered 48-bit page memory and streams them as byte-wide framed packets toward the host-interface FIFO. Sits between the receiver page writer, which ping-pongs pages and flags the finished one on `mem_block`, and the USB/FIFO byte link. It owns the memory read port, frame sequencing and page-overrun bookkeeping.

---
 rtl/rx_frame_sender_if.sv | 19 +
 rtl/rx_frame_sender.sv | 230 +++++++++++++++++++++++
 tb/tb_rx_frame_sender.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_sender_if.sv
// rx_frame_sender_if: byte-wide valid/ready link toward the host FIFO.
// The sender drives data/valid through master; the FIFO answers ready through slave.
interface rx_frame_sender_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/rx_frame_sender.sv
// rx_frame_sender: streams completed 48-bit RX pages as framed byte packets.
// Define RX_FRAME_CRC_EN to append a CRC-16/CCITT-FALSE trailer to each frame.
module rx_frame_sender #(
    parameter int         WORDS = 82,
    parameter logic [7:0] SYNC0 = 8'h5A,
    parameter logic [7:0] SYNC1 = 8'hA5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx_on,
    input  logic              mem_block,
    output logic [7:0]        rd_addr,
    input  logic [47:0]       rd_data,
    rx_frame_sender_if.master tx,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        seq
);

    typedef enum logic [2:0] {
        IDLE, HDR, RD, CAP, BYTE, TRL, DONE
    } state_t;

    localparam logic [6:0] LAST = 7'(WORDS - 1);

    state_t      state, state_d;
    logic        mb_q;
    logic        pend, pend_d;
    logic        pend_page, pend_page_d;
    logic        page, page_d;
    logic [6:0]  idx, idx_d;
    logic [1:0]  hcnt, hcnt_d;
    logic [2:0]  bcnt, bcnt_d;
    logic [47:0] sh, sh_d;
    logic [7:0]  rd_addr_d;
    logic [7:0]  txd, txd_d;
    logic        txv, txv_d;
    logic        overrun_d;
    logic [7:0]  seq_d;
    logic        toggle, xfer, consume;

`ifdef RX_FRAME_CRC_EN
    logic [15:0] crc, crc_d, crc_nx;
    logic        tcnt, tcnt_d;

    function automatic logic [15:0] crc_upd(input logic [15:0] c,
                                            input logic [7:0]  d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    assign crc_nx = crc_upd(crc, txd);
`endif

    assign toggle      = mem_block ^ mb_q;
    assign xfer        = txv & tx.tx_ready;
    assign busy        = (state != IDLE);
    assign tx.tx_data  = txd;
    assign tx.tx_valid = txv;

    always_comb begin
        state_d     = state;
        pend_d      = pend;
        pend_page_d = pend_page;
        page_d      = page;
        idx_d       = idx;
        hcnt_d      = hcnt;
        bcnt_d      = bcnt;
        sh_d        = sh;
        rd_addr_d   = rd_addr;
        txd_d       = txd;
        txv_d       = txv;
        overrun_d   = overrun;
        seq_d       = seq;
        consume     = 1'b0;
`ifdef RX_FRAME_CRC_EN
        crc_d       = crc;
        tcnt_d      = tcnt;
`endif
        unique case (state)
            IDLE: begin
                if (pend) begin
                    consume = 1'b1;
                    state_d = HDR;
                    page_d  = pend_page;
                    idx_d   = '0;
                    hcnt_d  = '0;
                    txv_d   = 1'b1;
                    txd_d   = SYNC0;
`ifdef RX_FRAME_CRC_EN
                    crc_d   = 16'hFFFF;
`endif
                end
            end
            HDR: begin
                if (xfer) begin
`ifdef RX_FRAME_CRC_EN
                    crc_d = crc_nx;
`endif
                    if (hcnt == 2'd2) begin
                        txv_d     = 1'b0;
                        rd_addr_d = {page, idx};
                        state_d   = RD;
                    end else begin
                        hcnt_d = hcnt + 2'd1;
                        txd_d  = (hcnt == 2'd0) ? SYNC1 : seq;
                    end
                end
            end
            RD: state_d = CAP;
            CAP: begin
                sh_d    = rd_data;
                txd_d   = rd_data[47:40];
                txv_d   = 1'b1;
                bcnt_d  = '0;
                state_d = BYTE;
            end
            BYTE: begin
                if (xfer) begin
`ifdef RX_FRAME_CRC_EN
                    crc_d = crc_nx;
`endif
                    if (bcnt == 3'd5) begin
                        txv_d = 1'b0;
                        if (idx == LAST) begin
`ifdef RX_FRAME_CRC_EN
                            txv_d   = 1'b1;
                            txd_d   = crc_nx[15:8];
                            tcnt_d  = 1'b0;
                            state_d = TRL;
`else
                            state_d = DONE;
`endif
                        end else begin
                            idx_d     = idx + 7'd1;
                            rd_addr_d = {page, idx + 7'd1};
                            state_d   = RD;
                        end
                    end else begin
                        bcnt_d = bcnt + 3'd1;
                        sh_d   = sh << 8;
                        txd_d  = sh[39:32];
                    end
                end
            end
            TRL: begin
`ifdef RX_FRAME_CRC_EN
                if (xfer) begin
                    if (tcnt) begin
                        txv_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        tcnt_d = 1'b1;
                        txd_d  = crc[7:0];
                    end
                end
`else
                state_d = DONE;
`endif
            end
            DONE: begin
                seq_d   = seq + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A toggle landing as IDLE consumes the old request stays pending
        if (consume) pend_d = 1'b0;
        if (toggle) begin
            pend_d      = 1'b1;
            pend_page_d = mem_block;
            if (pend && !consume) overrun_d = 1'b1;
        end

        if (!rx_on) begin
            state_d   = IDLE;
            txv_d     = 1'b0;
            pend_d    = 1'b0;
            overrun_d = 1'b0;
            seq_d     = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mb_q      <= 1'b0;
            pend      <= 1'b0;
            pend_page <= 1'b0;
            page      <= 1'b0;
            idx       <= '0;
            hcnt      <= '0;
            bcnt      <= '0;
            sh        <= '0;
            rd_addr   <= '0;
            txd       <= '0;
            txv       <= 1'b0;
            overrun   <= 1'b0;
            seq       <= '0;
`ifdef RX_FRAME_CRC_EN
            crc       <= 16'hFFFF;
            tcnt      <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            mb_q      <= mem_block;
            pend      <= pend_d;
            pend_page <= pend_page_d;
            page      <= page_d;
            idx       <= idx_d;
            hcnt      <= hcnt_d;
            bcnt      <= bcnt_d;
            sh        <= sh_d;
            rd_addr   <= rd_addr_d;
            txd       <= txd_d;
            txv       <= txv_d;
            overrun   <= overrun_d;
            seq       <= seq_d;
`ifdef RX_FRAME_CRC_EN
            crc       <= crc_d;
            tcnt      <= tcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_rx_frame_sender.sv
// tb_rx_frame_sender: randomized scoreboard bench for rx_frame_sender.
// Expected frames are built from page contents; a monitor pops and compares.
module tb_rx_frame_sender;

    localparam int WORDS = 82;
`ifdef RX_FRAME_CRC_EN
    localparam int TRL_N = 2;
`else
    localparam int TRL_N = 0;
`endif
    localparam int FRAME_B = 3 + 6 * WORDS + TRL_N;
    localparam int FRAME_C = 3 + 8 * WORDS + TRL_N + 1;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_on = 1'b0;
    logic        mem_block = 1'b0;
    logic [7:0]  rd_addr;
    logic [47:0] rd_data;
    logic        busy, overrun;
    logic [7:0]  seq;

    rx_frame_sender_if tx();

    always #5 clock = ~clock;

    rx_frame_sender #(.WORDS(WORDS)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rx_on     (rx_on),
        .mem_block (mem_block),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .tx        (tx),
        .busy      (busy),
        .overrun   (overrun),
        .seq       (seq)
    );

    logic [47:0] mem [256];
    always @(posedge clock) rd_data <= mem[rd_addr];

    typedef struct {
        logic [7:0] b;
        logic       pg;
        int         pos;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   tb_seq = 0;
    logic rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [15:0] c,
                                          input logic [7:0]  d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    task automatic push_frame(input logic pg);
        logic [7:0]  bytes [$];
        logic [15:0] crc;
        logic [47:0] w;
        exp_t        x;
        bytes.push_back(8'h5A);
        bytes.push_back(8'hA5);
        bytes.push_back(8'(tb_seq));
        for (int n = 0; n < WORDS; n++) begin
            w = mem[(pg ? 128 : 0) + n];
            for (int k = 5; k >= 0; k--)
                bytes.push_back(8'(w >> (8 * k)));
        end
        crc = 16'hFFFF;
        foreach (bytes[i]) crc = crc16(crc, bytes[i]);
`ifdef RX_FRAME_CRC_EN
        bytes.push_back(crc[15:8]);
        bytes.push_back(crc[7:0]);
`endif
        foreach (bytes[i]) begin
            x.b   = bytes[i];
            x.pg  = pg;
            x.pos = i;
            q.push_back(x);
        end
        tb_seq = (tb_seq + 1) % 256;
    endtask

    int   nbytes = 0;
    int   busy_cyc = 0;
    int   gap = 0;
    int   last_gap = 0;
    logic pv = 1'b0, pr = 1'b0, prx = 1'b0, pb = 1'b0;
    logic [7:0] pd = '0;

    always @(negedge clock) begin
        if (pv && !pr && prx && reset_n) begin
            check("hold_valid", tx.tx_valid, 1);
            check("hold_data", tx.tx_data, pd);
        end
        if (tx.tx_valid && tx.tx_ready) begin
            nbytes++;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte: got %0h expected none",
                         tx.tx_data);
            end else begin
                e = q.pop_front();
                check($sformatf("byte%0d", e.pos), tx.tx_data, e.b);
                if (e.pos >= 3) check("rd_page", rd_addr[7], e.pg);
            end
        end
        if (busy) busy_cyc++;
        if (busy && !pb) last_gap = gap;
        gap = busy ? 0 : gap + 1;
        pv  = tx.tx_valid;
        pr  = tx.tx_ready;
        pd  = tx.tx_data;
        prx = rx_on;
        pb  = busy;
    end

    initial begin
        tx.tx_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            tx.tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int maxc, input string name);
        int c = 0;
        while ((q.size() != 0 || busy) && c < maxc) begin
            @(posedge clock);
            #1;
            c++;
        end
        n_checks++;
        if (c >= maxc) begin
            n_fail++;
            $display("FAIL timeout_%s: got %0d left expected 0", name,
                     q.size());
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_tx_data"}, tx.tx_data, 0);
        check({tag, "_tx_valid"}, tx.tx_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_seq"}, seq, 0);
    endtask

    initial begin
        logic [6:0] nn;
        int         snap;
        for (int a = 0; a < 256; a++)
            mem[a] = {16'($urandom), 32'($urandom)};
        for (int n = 0; n < WORDS; n++) begin
            nn = 7'(n);
            mem[128 + n] = {8{nn[5:0]}};
        end

        cyc(3);
        check_reset("rst");
        reset_n = 1'b1;
        cyc(2);
        check_reset("post_rst");
        rx_on = 1'b1;
        cyc(1);

        // pattern page 1, ready always high
        busy_cyc = 0;
        nbytes = 0;
        mem_block = ~mem_block;
        push_frame(mem_block);
        @(posedge clock);
        @(negedge clock);
        check("lat_t1_valid", tx.tx_valid, 0);
        @(negedge clock);
        check("lat_t2_valid", tx.tx_valid, 1);
        check("lat_t2_data", tx.tx_data, 8'h5A);
        wait_done(2000, "s1");
        check("s1_bytes", nbytes, FRAME_B);
        check("s1_cycles", busy_cyc, FRAME_C);
        check("s1_seq", seq, 1);
        check("s1_rd_addr", rd_addr, {1'b1, 7'(WORDS - 1)});
        check("s1_overrun", overrun, 0);

        // same pattern through page 0 with random backpressure
        for (int n = 0; n < WORDS; n++) mem[n] = mem[128 + n];
        rand_rdy = 1'b1;
        nbytes = 0;
        mem_block = ~mem_block;
        push_frame(mem_block);
        wait_done(6000, "s2");
        rand_rdy = 1'b0;
        check("s2_bytes", nbytes, FRAME_B);
        check("s2_seq", seq, 8'(tb_seq));
        for (int a = 0; a < 256; a++)
            mem[a] = {16'($urandom), 32'($urandom)};
        cyc(2);

        // second page arrives mid-frame
        mem_block = ~mem_block;
        push_frame(mem_block);
        cyc(100);
        mem_block = ~mem_block;
        push_frame(mem_block);
        wait_done(4000, "s3a");
        check("s3a_overrun", overrun, 0);
        check("s3a_gap", last_gap, 1);
        check("s3a_seq", seq, 8'(tb_seq));
        cyc(2);

        // third toggle before the pending frame starts
        mem_block = ~mem_block;
        push_frame(mem_block);
        cyc(100);
        mem_block = ~mem_block;
        cyc(100);
        mem_block = ~mem_block;
        push_frame(mem_block);
        cyc(1);
        @(negedge clock);
        check("s3b_overrun_set", overrun, 1);
        wait_done(4000, "s3b");
        check("s3b_overrun_held", overrun, 1);
        check("s3b_seq", seq, 8'(tb_seq));
        cyc(2);

        // abort after 200 payload bytes
        nbytes = 0;
        mem_block = ~mem_block;
        push_frame(mem_block);
        snap = 0;
        while (nbytes < 203 && snap < 2000) begin
            @(posedge clock);
            #1;
            snap++;
        end
        check("s4_reach200", nbytes >= 203, 1);
        rx_on = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("s4_valid", tx.tx_valid, 0);
        check("s4_busy", busy, 0);
        check("s4_seq", seq, 0);
        check("s4_overrun", overrun, 0);
        q.delete();
        tb_seq = 0;
        cyc(20);
        rx_on = 1'b1;
        snap = nbytes;
        cyc(50);
        check("s4_quiet", nbytes, snap);
        check("s4_quiet_busy", busy, 0);
        mem_block = ~mem_block;
        push_frame(mem_block);
        wait_done(2000, "s4");
        check("s4_seq_after", seq, 1);

        // asynchronous reset mid-frame
        mem_block = ~mem_block;
        push_frame(mem_block);
        cyc(50);
        #1;
        reset_n = 1'b0;
        mem_block = 1'b0;
        #1;
        check_reset("arst");
        #1;
        reset_n = 1'b1;
        q.delete();
        tb_seq = 0;
        cyc(5);
        check("arst_idle", busy, 0);

        // all-zero page
        for (int n = 0; n < WORDS; n++) mem[128 + n] = '0;
        nbytes = 0;
        mem_block = ~mem_block;
        push_frame(mem_block);
        wait_done(2000, "s6");
        check("s6_bytes", nbytes, FRAME_B);
        check("s6_seq", seq, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
